// File: rtl/prio_codec_pkg.sv
// -----------------------------------------------------------------------------
// prio_codec_pkg
// Shared types and helpers for the sequential priority codec.
//   state_e  : scan FSM states (ST_IDLE, ST_BUSY)
//   hi_idx   : index of the highest set bit (0 for an all-zero vector)
//   popcount : number of set bits; only the PRIO_CODEC_REMAIN_EN build uses it
// Helpers take a MaxN-wide vector; callers zero-extend narrower vectors.
// -----------------------------------------------------------------------------
package prio_codec_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    // Widest request vector the helpers support.
    localparam int unsigned MaxN = 256;

    function automatic int unsigned hi_idx(input logic [MaxN-1:0] v);
        int unsigned idx;
        idx = 0;
        // Ascending scan: the last hit is the highest set bit.
        for (int unsigned i = 0; i < MaxN; i++) begin
            if (v[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

    function automatic int unsigned popcount(input logic [MaxN-1:0] v);
        int unsigned cnt;
        cnt = 0;
        for (int unsigned i = 0; i < MaxN; i++) begin
            cnt = cnt + {31'd0, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/prio_enc_onehot.sv
// -----------------------------------------------------------------------------
// prio_enc_onehot
// Combinational highest-priority encoder (bit N-1 wins).
//   i_v      : input vector
//   o_idx    : binary index of the highest set bit (0 when o_none)
//   o_onehot : 1 << o_idx, or 0 when o_none
//   o_none   : i_v is all-zero
// -----------------------------------------------------------------------------
module prio_enc_onehot
    import prio_codec_pkg::*;
#(
    parameter  int N     = 8,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     i_v,
    output logic [IDX_W-1:0] o_idx,
    output logic [N-1:0]     o_onehot,
    output logic             o_none
);

    always_comb begin
        o_none   = (i_v == '0);
        o_idx    = IDX_W'(hi_idx(MaxN'(i_v)));
        o_onehot = o_none ? '0 : (N'(1) << o_idx);
    end

endmodule

// File: rtl/prio_codec_scan.sv
// -----------------------------------------------------------------------------
// prio_codec_scan
// Sequential priority codec: accepts an N-bit request vector on a valid/ready
// handshake, then emits one beat per set bit, highest index first. An all-zero
// vector yields a single beat flagged out_none.
//
// Ports:
//   clk, rst    : clock (rising edge), asynchronous active-high reset
//   en          : acceptance enable; low blocks new vectors only
//   in_valid    : request vector valid
//   in_req      : request vector, bit N-1 highest priority
//   in_ready    : a vector can be accepted this cycle
//   out_valid   : beat valid
//   out_ready   : consumer accepts the beat
//   out_idx     : binary index of the granted bit
//   out_onehot  : one-hot grant (0 when out_none)
//   out_last    : final beat of the current vector
//   out_none    : the accepted vector was all-zero
//   out_remain  : beats left after the current one (PRIO_CODEC_REMAIN_EN only)
//
// Build option: define PRIO_CODEC_REMAIN_EN to add the out_remain port.
// -----------------------------------------------------------------------------
module prio_codec_scan
    import prio_codec_pkg::*;
#(
    parameter  int N     = 8,
    localparam int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    input  logic [N-1:0]     in_req,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic [N-1:0]     out_onehot,
    output logic             out_last,
    output logic             out_none
`ifdef PRIO_CODEC_REMAIN_EN
    ,
    output logic [IDX_W:0]   out_remain
`endif
);

    state_e           r_state;
    state_e           w_state_next;

    logic [N-1:0]     r_pending;
    logic [IDX_W-1:0] r_idx;
    logic [N-1:0]     r_onehot;
    logic             r_last;
    logic             r_none;

    logic             w_fire;
    logic             w_accept;
    logic             w_advance;
    logic             w_load;
    logic [N-1:0]     w_src;
    logic [IDX_W-1:0] w_enc_idx;
    logic [N-1:0]     w_enc_onehot;
    logic             w_enc_none;
    logic [N-1:0]     w_pending_next;

    // Handshake and datapath control. in_ready looks at out_ready directly so a
    // new vector can replace the last beat of the previous one without a bubble.
    always_comb begin
        w_fire    = (r_state == ST_BUSY) & out_ready;
        in_ready  = en & ~rst & ((r_state == ST_IDLE) | (w_fire & r_last));
        w_accept  = in_valid & in_ready;
        w_advance = w_fire & ~r_last;
        w_load    = w_accept | w_advance;
        w_src     = w_accept ? in_req : r_pending;
    end

    // One encoder serves both the fresh vector and the pending remainder.
    prio_enc_onehot #(
        .N (N)
    ) u_enc (
        .i_v      (w_src),
        .o_idx    (w_enc_idx),
        .o_onehot (w_enc_onehot),
        .o_none   (w_enc_none)
    );

    always_comb begin
        w_pending_next = w_src & ~w_enc_onehot;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (w_fire && r_last && !w_accept) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Beat registers: load on accept or on consuming a non-last beat; clear when
    // the last beat retires with nothing new behind it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= '0;
            r_idx     <= '0;
            r_onehot  <= '0;
            r_last    <= 1'b0;
            r_none    <= 1'b0;
        end else if (w_load) begin
            r_pending <= w_pending_next;
            r_idx     <= w_enc_idx;
            r_onehot  <= w_enc_onehot;
            r_last    <= (w_pending_next == '0);
            r_none    <= w_enc_none;
        end else if (w_fire) begin
            r_pending <= '0;
            r_idx     <= '0;
            r_onehot  <= '0;
            r_last    <= 1'b0;
            r_none    <= 1'b0;
        end
    end

`ifdef PRIO_CODEC_REMAIN_EN
    logic [IDX_W:0] r_remain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_remain <= '0;
        end else if (w_load) begin
            r_remain <= (IDX_W + 1)'(popcount(MaxN'(w_pending_next)));
        end else if (w_fire) begin
            r_remain <= '0;
        end
    end
`else
    // No remaining-beat counter in this build.
`endif

    // Output logic.
    always_comb begin
        out_valid  = (r_state == ST_BUSY);
        out_idx    = r_idx;
        out_onehot = r_onehot;
        out_last   = r_last;
        out_none   = r_none;
`ifdef PRIO_CODEC_REMAIN_EN
        out_remain = r_remain;
`endif
    end

endmodule

// File: tb/tb_prio_codec_scan.sv
module tb_prio_codec_scan;

    typedef struct packed {
        logic [2:0] idx;
        logic [7:0] oh;
        logic       last;
        logic       none;
        logic [3:0] rem;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_req = 8'h00;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [2:0] out_idx;
    logic [7:0] out_onehot;
    logic       out_last;
    logic       out_none;
`ifdef PRIO_CODEC_REMAIN_EN
    logic [3:0] out_remain;
`endif

    int    total = 0;
    int    bad = 0;
    beat_t sb[$];

    prio_codec_scan #(
        .N (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .in_valid   (in_valid),
        .in_req     (in_req),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_idx    (out_idx),
        .out_onehot (out_onehot),
        .out_last   (out_last),
        .out_none   (out_none)
`ifdef PRIO_CODEC_REMAIN_EN
        ,
        .out_remain (out_remain)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    // Expected beats of one vector, highest set bit first.
    task automatic push_vec(input logic [7:0] v);
        beat_t      b;
        logic [7:0] lower;
        if (v == 8'h00) begin
            b = '{idx: 3'd0, oh: 8'h00, last: 1'b1, none: 1'b1, rem: 4'd0};
            sb.push_back(b);
        end else begin
            for (int i = 7; i >= 0; i--) begin
                if (v[i]) begin
                    lower  = v & ((8'h01 << i) - 8'h01);
                    b.idx  = 3'(i);
                    b.oh   = 8'h01 << i;
                    b.last = (lower == 8'h00);
                    b.none = 1'b0;
                    b.rem  = 4'($countones(lower));
                    sb.push_back(b);
                end
            end
        end
    endtask

    task automatic test_reset();
        en = 1'b1; in_valid = 1'b1; in_req = 8'hFF; out_ready = 1'b1;
        @(negedge clk); #1;
        total++;
        if ({out_valid, out_idx, out_onehot, out_last, out_none} !== 14'd0) begin
            bad++;
            $display("FAIL reset_outputs got v=%b i=%0d oh=%h l=%b n=%b want all 0",
                     out_valid, out_idx, out_onehot, out_last, out_none);
        end
        total++;
        if (in_ready !== 1'b0) begin
            bad++; $display("FAIL reset_in_ready got %b want 0", in_ready);
        end
        in_valid = 1'b0; en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_scan_a4();
        beat_t exp;
        int    nb = 0;
        @(negedge clk);
        en = 1'b1; in_valid = 1'b1; in_req = 8'hA4; out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL a4_ready_idle got %b want 1", in_ready); end
        if (in_valid && in_ready) push_vec(in_req);
        @(negedge clk);
        in_valid = 1'b0; in_req = 8'h5A;
        for (int c = 0; c < 10 && nb < 3; c++) begin
            #1;
            total++;
            if (out_valid !== 1'b1) begin
                bad++; $display("FAIL a4_valid cyc=%0d got %b want 1", c, out_valid);
            end else begin
                total++;
                if (in_ready !== ((nb == 2) ? 1'b1 : 1'b0)) begin
                    bad++; $display("FAIL a4_in_ready beat=%0d got %b want %b", nb, in_ready, nb == 2);
                end
                total++;
                if (sb.size() == 0) begin bad++; $display("FAIL a4_sb_empty got idx=%0d", out_idx); end
                else begin
                    exp = sb.pop_front();
                    if ({out_idx, out_onehot, out_last, out_none} !== {exp.idx, exp.oh, exp.last, exp.none}) begin
                        bad++;
                        $display("FAIL a4_beat got i=%0d oh=%h l=%b n=%b want i=%0d oh=%h l=%b n=%b",
                                 out_idx, out_onehot, out_last, out_none, exp.idx, exp.oh, exp.last, exp.none);
                    end
`ifdef PRIO_CODEC_REMAIN_EN
                    total++;
                    if (out_remain !== exp.rem) begin
                        bad++; $display("FAIL a4_remain got %0d want %0d", out_remain, exp.rem);
                    end
`endif
                end
                nb++;
            end
            @(negedge clk);
        end
        #1;
        total++;
        if (nb != 3 || out_valid !== 1'b0 || sb.size() != 0) begin
            bad++; $display("FAIL a4_end got beats=%0d valid=%b left=%0d want 3 0 0", nb, out_valid, sb.size());
        end
    endtask

    task automatic test_zero();
        beat_t exp;
        @(negedge clk);
        en = 1'b1; in_valid = 1'b1; in_req = 8'h00; out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL zero_ready got %b want 1", in_ready); end
        if (in_valid && in_ready) push_vec(in_req);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b1 || sb.size() == 0) begin
            bad++; $display("FAIL zero_valid got %b want 1", out_valid);
        end else begin
            exp = sb.pop_front();
            if ({out_idx, out_onehot, out_last, out_none} !== {exp.idx, exp.oh, exp.last, exp.none}) begin
                bad++;
                $display("FAIL zero_beat got i=%0d oh=%h l=%b n=%b want i=%0d oh=%h l=%b n=%b",
                         out_idx, out_onehot, out_last, out_none, exp.idx, exp.oh, exp.last, exp.none);
            end
        end
        @(negedge clk); #1;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL zero_idle got %b want 0", out_valid); end
    endtask

    task automatic test_backpressure();
        beat_t exp;
        int    nb = 0;
        @(negedge clk);
        en = 1'b1; in_valid = 1'b1; in_req = 8'hC0; out_ready = 1'b0;
        #1;
        if (in_valid && in_ready) push_vec(in_req);
        @(negedge clk);
        in_req = 8'h3C;   // stays offered; must not be taken while stalled
        for (int c = 0; c < 4; c++) begin
            #1;
            total++;
            if ({out_valid, out_idx, out_onehot, out_last, out_none, in_ready} !==
                {1'b1, 3'd7, 8'h80, 1'b0, 1'b0, 1'b0}) begin
                bad++;
                $display("FAIL bp_hold cyc=%0d got v=%b i=%0d oh=%h l=%b n=%b rdy=%b want 1 7 80 0 0 0",
                         c, out_valid, out_idx, out_onehot, out_last, out_none, in_ready);
            end
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 6 && nb < 2; c++) begin
            #1;
            total++;
            if (out_valid !== 1'b1 || sb.size() == 0) begin
                bad++; $display("FAIL bp_valid cyc=%0d got %b want 1", c, out_valid);
            end else begin
                exp = sb.pop_front();
                if ({out_idx, out_onehot, out_last, out_none, in_ready} !==
                    {exp.idx, exp.oh, exp.last, exp.none, exp.last}) begin
                    bad++;
                    $display("FAIL bp_beat got i=%0d oh=%h l=%b n=%b rdy=%b want i=%0d oh=%h l=%b n=%b rdy=%b",
                             out_idx, out_onehot, out_last, out_none, in_ready,
                             exp.idx, exp.oh, exp.last, exp.none, exp.last);
                end
                nb++;
            end
            @(negedge clk);
        end
        #1;
        total++;
        if (nb != 2 || out_valid !== 1'b0) begin
            bad++; $display("FAIL bp_end got beats=%0d valid=%b want 2 0", nb, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        beat_t exp;
        @(negedge clk);
        en = 1'b1; in_valid = 1'b1; in_req = 8'h02; out_ready = 1'b1;
        #1;
        if (in_valid && in_ready) push_vec(in_req);
        @(negedge clk);
        in_req = 8'h81;
        for (int c = 0; c < 3; c++) begin
            #1;
            if (c == 0) begin
                total++;
                if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready got %b want 1", in_ready); end
                if (in_valid && in_ready) push_vec(in_req);
            end
            total++;
            if (out_valid !== 1'b1 || sb.size() == 0) begin
                bad++; $display("FAIL b2b_valid cyc=%0d got %b want 1", c, out_valid);
            end else begin
                exp = sb.pop_front();
                if ({out_idx, out_onehot, out_last, out_none} !== {exp.idx, exp.oh, exp.last, exp.none}) begin
                    bad++;
                    $display("FAIL b2b_beat cyc=%0d got i=%0d oh=%h l=%b n=%b want i=%0d oh=%h l=%b n=%b",
                             c, out_idx, out_onehot, out_last, out_none, exp.idx, exp.oh, exp.last, exp.none);
                end
            end
            @(negedge clk);
            in_valid = 1'b0;
        end
        #1;
        total++;
        if (out_valid !== 1'b0 || sb.size() != 0) begin
            bad++; $display("FAIL b2b_end got valid=%b left=%0d want 0 0", out_valid, sb.size());
        end
    endtask

    task automatic test_async_reset();
        beat_t exp;
        @(negedge clk);
        en = 1'b1; in_valid = 1'b1; in_req = 8'hFF; out_ready = 1'b1;
        #1;
        if (in_valid && in_ready) push_vec(in_req);
        @(negedge clk);
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++;
            if (out_valid !== 1'b1 || sb.size() == 0) begin
                bad++; $display("FAIL ar_valid cyc=%0d got %b want 1", c, out_valid);
            end else begin
                exp = sb.pop_front();
                if ({out_idx, out_onehot, out_last} !== {exp.idx, exp.oh, exp.last}) begin
                    bad++;
                    $display("FAIL ar_beat got i=%0d oh=%h l=%b want i=%0d oh=%h l=%b",
                             out_idx, out_onehot, out_last, exp.idx, exp.oh, exp.last);
                end
            end
            @(negedge clk);
        end
        #1;
        total++;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL ar_pre got %b want 1", out_valid); end
        #1 rst = 1'b1;
        #1;
        total++;
        if ({out_valid, out_idx, out_onehot, out_last, out_none, in_ready} !== 15'd0) begin
            bad++;
            $display("FAIL ar_async got v=%b i=%0d oh=%h l=%b n=%b rdy=%b want all 0",
                     out_valid, out_idx, out_onehot, out_last, out_none, in_ready);
        end
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL ar_idle got valid=%b rdy=%b want 0 1", out_valid, in_ready);
        end
        in_valid = 1'b1; in_req = 8'h10;
        #1;
        if (in_valid && in_ready) push_vec(in_req);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b1 || sb.size() == 0) begin
            bad++; $display("FAIL ar_fresh_valid got %b want 1", out_valid);
        end else begin
            exp = sb.pop_front();
            if ({out_idx, out_onehot, out_last, out_none} !== {exp.idx, exp.oh, exp.last, exp.none}) begin
                bad++;
                $display("FAIL ar_fresh got i=%0d oh=%h l=%b n=%b want i=%0d oh=%h l=%b n=%b",
                         out_idx, out_onehot, out_last, out_none, exp.idx, exp.oh, exp.last, exp.none);
            end
        end
        @(negedge clk); #1;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL ar_end got %b want 0", out_valid); end
    endtask

    task automatic test_enable();
        beat_t exp;
        @(negedge clk);
        en = 1'b0; in_valid = 1'b1; in_req = 8'h08; out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            total++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
                bad++; $display("FAIL en_block cyc=%0d got rdy=%b valid=%b want 0 0", c, in_ready, out_valid);
            end
            @(negedge clk);
        end
        en = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL en_ready got %b want 1", in_ready); end
        if (in_valid && in_ready) push_vec(in_req);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b1 || sb.size() == 0) begin
            bad++; $display("FAIL en_valid got %b want 1", out_valid);
        end else begin
            exp = sb.pop_front();
            if ({out_idx, out_onehot, out_last, out_none} !== {exp.idx, exp.oh, exp.last, exp.none}) begin
                bad++;
                $display("FAIL en_beat got i=%0d oh=%h l=%b n=%b want i=%0d oh=%h l=%b n=%b",
                         out_idx, out_onehot, out_last, out_none, exp.idx, exp.oh, exp.last, exp.none);
            end
        end
        @(negedge clk); #1;
        total++;
        if (out_valid !== 1'b0 || sb.size() != 0) begin
            bad++; $display("FAIL en_end got valid=%b left=%0d want 0 0", out_valid, sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_scan_a4();
        test_zero();
        test_backpressure();
        test_back_to_back();
        test_async_reset();
        test_enable();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
